// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU datapath widths and feeder state encoding
package npu_pkg;

   localparam int NPU_DATA_W = 16;
   localparam int NPU_ACC_W  = 48;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } feeder_state_e;

endpackage

// File: rtl/npu_skew_line.sv
// rtl/npu_skew_line.sv - resettable fixed-depth register delay line
module npu_skew_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift d_i through DEPTH stages; reset empties the whole line at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/npu_pe_feeder.sv
// rtl/npu_pe_feeder.sv - loads inputs into a PE chain and streams skewed weight rows per neuron
module npu_pe_feeder
   import npu_pkg::*;
#(
   parameter int N_PE   = 4,
   parameter int PE_LAT = 1,
   parameter int ADDR_W = 8
) (
   input  logic                         CLK,
   input  logic                         npu_rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            cfg_num_neurons,
   output logic                         busy,
   output logic                         done,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NPU_DATA_W-1:0]        in_data,
   output logic                         wmem_rd_en,
   output logic [ADDR_W-1:0]            wmem_addr,
   input  logic [N_PE*NPU_DATA_W-1:0]   wmem_rdata,
   input  logic [NPU_ACC_W-1:0]         bias_rdata,
   output logic                         npu_pe_en,
   output logic [N_PE-1:0]              npu_pe_new_input_wren,
   output logic [NPU_DATA_W-1:0]        npu_pe_data_in,
   output logic [N_PE*NPU_DATA_W-1:0]   npu_pe_weight_in,
   output logic [NPU_ACC_W-1:0]         npu_pe_acc_in,
   output logic                         res_valid,
   output logic [ADDR_W-1:0]            res_idx
);

   localparam int LCNT_W    = (N_PE > 1) ? $clog2(N_PE) : 1;
   // rd_vld_q plus this many stages lands on the cycle the last PE holds the sum
   localparam int RES_DEPTH = 1 + N_PE * PE_LAT;

   feeder_state_e             state_q, state_d;
   logic [LCNT_W-1:0]         load_cnt_q, load_cnt_d;
   logic [ADDR_W-1:0]         issue_cnt_q, issue_cnt_d;
   logic [ADDR_W-1:0]         num_q, num_d;
   logic [ADDR_W-1:0]         res_idx_q, res_idx_d;
   logic [N_PE-1:0]           wren_q, wren_d;
   logic [NPU_DATA_W-1:0]     data_q, data_d;
   logic                      zero_done_q, zero_done_d;
   logic                      rd_vld_q;
   logic [N_PE*NPU_DATA_W-1:0] row_masked;
   logic [NPU_ACC_W-1:0]      bias_masked;
   logic                      last_load;
   logic                      last_issue;
   logic                      last_res;

   assign last_load  = (load_cnt_q == LCNT_W'(N_PE - 1));
   assign last_issue = (issue_cnt_q == num_q - ADDR_W'(1));
   assign last_res   = res_valid && (res_idx_q == num_q - ADDR_W'(1));

   // Next-state, counter and load-strobe decisions for the pass sequencer.
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      issue_cnt_d = issue_cnt_q;
      num_d       = num_q;
      res_idx_d   = res_idx_q;
      wren_d      = '0;
      data_d      = data_q;
      zero_done_d = 1'b0;

      if (res_valid) begin
         res_idx_d = res_idx_q + ADDR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_d       = cfg_num_neurons;
               res_idx_d   = '0;
               load_cnt_d  = '0;
               issue_cnt_d = '0;
               if (cfg_num_neurons != '0) begin
                  state_d = ST_LOAD;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               wren_d     = N_PE'(1) << load_cnt_q;
               data_d     = in_data;
               load_cnt_d = load_cnt_q + LCNT_W'(1);
               if (last_load) begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            issue_cnt_d = issue_cnt_q + ADDR_W'(1);
            if (last_issue) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_res) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered PE load outputs; rd_vld_q marks cycles carrying RAM data.
   always_ff @(posedge CLK or posedge npu_rst) begin
      if (npu_rst) begin
         state_q     <= ST_IDLE;
         load_cnt_q  <= '0;
         issue_cnt_q <= '0;
         num_q       <= '0;
         res_idx_q   <= '0;
         wren_q      <= '0;
         data_q      <= '0;
         zero_done_q <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         issue_cnt_q <= issue_cnt_d;
         num_q       <= num_d;
         res_idx_q   <= res_idx_d;
         wren_q      <= wren_d;
         data_q      <= data_d;
         zero_done_q <= zero_done_d;
         rd_vld_q    <= wmem_rd_en;
      end
   end

   assign busy       = (state_q == ST_LOAD) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_DONE) || zero_done_q;
   assign in_ready   = (state_q == ST_LOAD);
   assign wmem_rd_en = (state_q == ST_ISSUE);
   assign wmem_addr  = wmem_rd_en ? issue_cnt_q : '0;
   assign npu_pe_en  = busy;

   assign npu_pe_new_input_wren = wren_q;
   assign npu_pe_data_in        = data_q;
   assign res_idx               = res_idx_q;

   // Idle cycles push zeros so lanes without a neuron in flight stay quiet.
   assign row_masked  = rd_vld_q ? wmem_rdata : '0;
   assign bias_masked = rd_vld_q ? bias_rdata : '0;

   for (genvar k = 0; k < N_PE; k++) begin : g_lane
      npu_skew_line #(
         .WIDTH (NPU_DATA_W),
         .DEPTH (1 + k * PE_LAT)
      ) u_lane (
         .clk_i (CLK),
         .rst_i (npu_rst),
         .d_i   (row_masked[k*NPU_DATA_W +: NPU_DATA_W]),
         .q_o   (npu_pe_weight_in[k*NPU_DATA_W +: NPU_DATA_W])
      );
   end

   npu_skew_line #(
      .WIDTH (NPU_ACC_W),
      .DEPTH (1)
   ) u_bias (
      .clk_i (CLK),
      .rst_i (npu_rst),
      .d_i   (bias_masked),
      .q_o   (npu_pe_acc_in)
   );

   npu_skew_line #(
      .WIDTH (1),
      .DEPTH (RES_DEPTH)
   ) u_res_pipe (
      .clk_i (CLK),
      .rst_i (npu_rst),
      .d_i   (rd_vld_q),
      .q_o   (res_valid)
   );

endmodule

// File: tb/tb_npu_pe_feeder.sv
// tb/tb_npu_pe_feeder.sv - self-checking bench for npu_pe_feeder with a behavioural PE chain
module tb_npu_pe_feeder;

   localparam int N_PE    = 4;
   localparam int PE_LAT  = 1;
   localparam int ADDR_W  = 8;
   localparam int RES_LAT = 2 + N_PE * PE_LAT;

   logic                 CLK = 1'b0;
   logic                 npu_rst, start, in_valid;
   logic [ADDR_W-1:0]    cfg_num_neurons;
   logic [15:0]          in_data;
   logic                 busy, done, in_ready, wmem_rd_en, npu_pe_en, res_valid;
   logic [ADDR_W-1:0]    wmem_addr, res_idx;
   logic [N_PE*16-1:0]   wmem_rdata, npu_pe_weight_in;
   logic [47:0]          bias_rdata, npu_pe_acc_in;
   logic [N_PE-1:0]      npu_pe_new_input_wren;
   logic [15:0]          npu_pe_data_in;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   npu_pe_feeder #(.N_PE(N_PE), .PE_LAT(PE_LAT), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .npu_rst(npu_rst), .start(start), .cfg_num_neurons(cfg_num_neurons),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
      .bias_rdata(bias_rdata), .npu_pe_en(npu_pe_en),
      .npu_pe_new_input_wren(npu_pe_new_input_wren), .npu_pe_data_in(npu_pe_data_in),
      .npu_pe_weight_in(npu_pe_weight_in), .npu_pe_acc_in(npu_pe_acc_in),
      .res_valid(res_valid), .res_idx(res_idx)
   );

   // weight/bias RAM: one-cycle read latency, junk on the bus when not read
   logic [63:0] wmem_arr [256];
   logic [47:0] bias_arr [256];
   always @(posedge CLK) begin
      if (wmem_rd_en) begin
         wmem_rdata <= wmem_arr[wmem_addr];
         bias_rdata <= bias_arr[wmem_addr];
      end else begin
         wmem_rdata <= {$urandom(), $urandom()};
         bias_rdata <= {16'($urandom()), $urandom()};
      end
   end

   // behavioural PE chain: acc_out = acc_in + data*weight, one cycle per PE
   logic [15:0] pe_data [N_PE];
   logic [47:0] pe_acc  [N_PE];
   always @(posedge CLK or posedge npu_rst) begin
      if (npu_rst) begin
         for (int k = 0; k < N_PE; k++) begin
            pe_data[k] <= '0;
            pe_acc[k]  <= '0;
         end
      end else if (npu_pe_en) begin
         for (int k = 0; k < N_PE; k++) begin
            if (npu_pe_new_input_wren[k]) pe_data[k] <= npu_pe_data_in;
            if (k == 0)
               pe_acc[k] <= npu_pe_acc_in + 48'(pe_data[k]) * 48'(npu_pe_weight_in[k*16 +: 16]);
            else
               pe_acc[k] <= pe_acc[k-1] + 48'(pe_data[k]) * 48'(npu_pe_weight_in[k*16 +: 16]);
         end
      end
   end

   // observation log
   logic [N_PE-1:0] ob_wren [$];
   logic [15:0]     ob_wdata [$];
   int              ob_wcyc [$];
   logic [7:0]      ob_addr [$];
   int              ob_rcyc [$];
   logic [47:0]     ob_res [$];
   logic [7:0]      ob_idx [$];
   int              ob_rescyc [$];
   int              ob_done [$];
   logic            ob_done_busy [$];
   int              hs_cyc [$];
   int              ob_busy_cnt, ob_en_cnt;

   always @(negedge CLK) begin
      if (!npu_rst) begin
         if (npu_pe_new_input_wren != '0) begin
            ob_wren.push_back(npu_pe_new_input_wren);
            ob_wdata.push_back(npu_pe_data_in);
            ob_wcyc.push_back(cyc);
         end
         if (wmem_rd_en) begin
            ob_addr.push_back(wmem_addr);
            ob_rcyc.push_back(cyc);
         end
         if (res_valid) begin
            ob_res.push_back(pe_acc[N_PE-1]);
            ob_idx.push_back(res_idx);
            ob_rescyc.push_back(cyc);
         end
         if (done) begin
            ob_done.push_back(cyc);
            ob_done_busy.push_back(busy);
         end
         if (busy) ob_busy_cnt++;
         if (npu_pe_en) ob_en_cnt++;
      end
   end

   logic [15:0] cur_words [N_PE];
   logic [47:0] exp_q [$];

   typedef struct packed {
      logic [7:0]        n;
      logic [3:0][15:0]  words;
      logic [2:0][15:0]  w;
      logic [47:0]       b;
      logic [15:0]       vpat;
      logic [7:0]        vlen;
      logic [2:0][47:0]  exp_res;
   } vec_t;

   vec_t vt [4];

   function automatic vec_t mk(input logic [7:0] n, input logic [63:0] words, input logic [47:0] w,
                               input logic [47:0] b, input logic [15:0] vpat, input logic [7:0] vlen,
                               input logic [143:0] exp_res);
      vec_t v;
      v.n = n; v.words = words; v.w = w; v.b = b; v.vpat = vpat; v.vlen = vlen; v.exp_res = exp_res;
      return v;
   endfunction

   function automatic logic [47:0] ref_sum(input int j);
      logic [47:0] s;
      s = bias_arr[j];
      for (int k = 0; k < N_PE; k++) s = s + 48'(cur_words[k]) * 48'(wmem_arr[j][k*16 +: 16]);
      return s;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic clear_obs();
      ob_wren.delete(); ob_wdata.delete(); ob_wcyc.delete();
      ob_addr.delete(); ob_rcyc.delete();
      ob_res.delete(); ob_idx.delete(); ob_rescyc.delete();
      ob_done.delete(); ob_done_busy.delete(); hs_cyc.delete();
      ob_busy_cnt = 0; ob_en_cnt = 0;
   endtask

   task automatic rand_setup(input int n);
      for (int k = 0; k < N_PE; k++) cur_words[k] = 16'($urandom());
      for (int j = 0; j < n; j++) begin
         wmem_arr[j] = {$urandom(), $urandom()};
         bias_arr[j] = {16'($urandom()), $urandom()};
      end
      exp_q.delete();
      for (int j = 0; j < n; j++) exp_q.push_back(ref_sum(j));
   endtask

   task automatic run_pass(input int n, input logic [15:0] vpat, input int vlen,
                           input bit rnd_gaps, input bit poke);
      int start_cyc, i, t, b, done_cyc;
      bit poked;
      clear_obs();
      start = 1'b1;
      cfg_num_neurons = 8'(n);
      start_cyc = cyc;
      step();
      start = 1'b0;
      cfg_num_neurons = 8'($urandom());
      check("busy_after_start", 64'(busy), 64'(n != 0));
      i = 0;
      t = 0;
      if (n != 0) begin
         while (i < N_PE && t < 200) begin
            if (t < vlen) in_valid = vpat[t];
            else if (rnd_gaps) in_valid = 1'($urandom_range(0, 1));
            else in_valid = 1'b1;
            in_data = in_valid ? cur_words[i] : 16'($urandom());
            if (in_valid && in_ready) begin
               hs_cyc.push_back(cyc);
               i++;
            end
            step();
            t++;
         end
         check("load_handshakes", 64'(i), 64'(N_PE));
      end
      poked = 1'b0;
      b = 0;
      while (ob_done.size() == 0 && b < n + 40) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = 16'($urandom());
         start = 1'b0;
         if (poke && !poked && ob_addr.size() > 0) begin
            start = 1'b1;
            cfg_num_neurons = 8'($urandom_range(1, 255));
            poked = 1'b1;
         end
         step();
         b++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      repeat (2) step();
      check("done_pulses", 64'(ob_done.size()), 64'(1));
      done_cyc = (ob_done.size() > 0) ? ob_done[0] : -1;
      if (ob_done_busy.size() > 0) check("busy_at_done", 64'(ob_done_busy[0]), 64'(0));
      if (n == 0) begin
         check("zero_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
         check("zero_rd_count", 64'(ob_addr.size()), 64'(0));
         check("zero_wren_count", 64'(ob_wren.size()), 64'(0));
         check("zero_busy_cycles", 64'(ob_busy_cnt), 64'(0));
      end else begin
         check("wren_count", 64'(ob_wren.size()), 64'(N_PE));
         for (int k = 0; k < N_PE && k < ob_wren.size(); k++) begin
            check("wren_onehot", 64'(ob_wren[k]), 64'(1 << k));
            check("wren_data", 64'(ob_wdata[k]), 64'(cur_words[k]));
            if (k < hs_cyc.size()) check("wren_cycle", 64'(ob_wcyc[k]), 64'(hs_cyc[k] + 1));
         end
         check("rd_count", 64'(ob_addr.size()), 64'(n));
         if (ob_rcyc.size() > 0 && hs_cyc.size() == N_PE)
            check("issue_start_cycle", 64'(ob_rcyc[0]), 64'(hs_cyc[N_PE-1] + 1));
         for (int j = 0; j < n && j < ob_addr.size(); j++) begin
            check("rd_addr", 64'(ob_addr[j]), 64'(j));
            check("rd_cycle", 64'(ob_rcyc[j]), 64'(ob_rcyc[0] + j));
         end
         check("res_count", 64'(ob_res.size()), 64'(n));
         for (int j = 0; j < n && j < ob_res.size(); j++) begin
            check("res_value", 64'(ob_res[j]), 64'(exp_q[j]));
            check("res_idx", 64'(ob_idx[j]), 64'(j));
            if (j < ob_rcyc.size()) check("res_latency", 64'(ob_rescyc[j]), 64'(ob_rcyc[j] + RES_LAT));
         end
         if (ob_rescyc.size() > 0 && done_cyc >= 0)
            check("done_after_last_res", 64'(done_cyc), 64'(ob_rescyc[ob_rescyc.size()-1] + 1));
         if (done_cyc >= 0) begin
            check("busy_cycles", 64'(ob_busy_cnt), 64'(done_cyc - start_cyc - 1));
            check("pe_en_cycles", 64'(ob_en_cnt), 64'(done_cyc - start_cyc - 1));
         end
      end
      check("idle_weight_zero", 64'(npu_pe_weight_in), 64'(0));
      check("idle_acc_zero", 64'(npu_pe_acc_in), 64'(0));
      check("idle_res_valid", 64'(res_valid), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int i, t, n;
      npu_rst = 1'b1; start = 1'b0; cfg_num_neurons = '0; in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_rd_en", 64'(wmem_rd_en), 64'(0));
      check("rst_addr", 64'(wmem_addr), 64'(0));
      check("rst_pe_en", 64'(npu_pe_en), 64'(0));
      check("rst_wren", 64'(npu_pe_new_input_wren), 64'(0));
      check("rst_data_in", 64'(npu_pe_data_in), 64'(0));
      check("rst_weight", 64'(npu_pe_weight_in), 64'(0));
      check("rst_acc", 64'(npu_pe_acc_in), 64'(0));
      check("rst_res_valid", 64'(res_valid), 64'(0));
      check("rst_res_idx", 64'(res_idx), 64'(0));
      step();
      npu_rst = 1'b0;

      // directed vectors: one neuron, three neurons, gapped load, zero neurons
      vt[0] = mk(8'd1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd0, 16'd0, 16'd1}, 48'd10, 16'h0, 8'd0,
                 {48'd0, 48'd0, 48'd20});
      vt[1] = mk(8'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd3, 16'd2, 16'd1}, 48'd0, 16'h0, 8'd0,
                 {48'd30, 48'd20, 48'd10});
      vt[2] = mk(8'd1, {16'd8, 16'd7, 16'd6, 16'd5}, {16'd0, 16'd0, 16'd2}, 48'd1, 16'h0059, 8'd7,
                 {48'd0, 48'd0, 48'd53});
      vt[3] = mk(8'd0, 64'd0, 48'd0, 48'd0, 16'h0, 8'd0, 144'd0);
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < N_PE; k++) cur_words[k] = vt[v].words[k];
         for (int j = 0; j < 3; j++) begin
            wmem_arr[j] = {4{vt[v].w[j]}};
            bias_arr[j] = vt[v].b;
         end
         exp_q.delete();
         for (int j = 0; j < int'(vt[v].n); j++) exp_q.push_back(vt[v].exp_res[j]);
         run_pass(int'(vt[v].n), vt[v].vpat, int'(vt[v].vlen), 1'b0, 1'b0);
      end

      // start re-pulsed and cfg changed mid-pass
      rand_setup(4);
      run_pass(4, 16'h0, 0, 1'b1, 1'b1);

      // randomized passes against the reference sums
      for (int r = 0; r < 6; r++) begin
         n = (r == 5) ? 30 : $urandom_range(1, 12);
         rand_setup(n);
         run_pass(n, 16'h0, 0, 1'b1, 1'b0);
      end

      // asynchronous reset in the middle of ISSUE
      rand_setup(6);
      clear_obs();
      start = 1'b1;
      cfg_num_neurons = 8'd6;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      i = 0;
      t = 0;
      while (i < N_PE && t < 50) begin
         in_data = cur_words[i];
         if (in_ready) i++;
         step();
         t++;
      end
      in_valid = 1'b0;
      t = 0;
      while (!wmem_rd_en && t < 50) begin
         step();
         t++;
      end
      check("abort_issue_reached", 64'(wmem_rd_en), 64'(1));
      @(posedge CLK);
      #3 npu_rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_rd_en", 64'(wmem_rd_en), 64'(0));
      check("abort_weight", 64'(npu_pe_weight_in), 64'(0));
      check("abort_acc", 64'(npu_pe_acc_in), 64'(0));
      check("abort_wren", 64'(npu_pe_new_input_wren), 64'(0));
      check("abort_res_valid", 64'(res_valid), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_res_idx", 64'(res_idx), 64'(0));
      step();
      clear_obs();
      npu_rst = 1'b0;
      repeat (20) step();
      check("abort_no_res", 64'(ob_res.size()), 64'(0));
      check("abort_no_done", 64'(ob_done.size()), 64'(0));
      rand_setup(5);
      run_pass(5, 16'h0, 0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
